decoder38_hold: RTL and testbench

Registered 3-to-8 decoder with hold timer. It is the receive end of the 3-bit code + indicator pair produced by the board's priority encoder. Each accepted code is decoded to one-hot and driven to the LED bank for a fixed hold window, optionally accumulating into a sticky mask. A valid/ready handshake throttles the upstream source while a hold window is running.

---
 rtl/decoder38_pkg.sv | 18 +
 rtl/decoder38_hold_timer.sv | 41 ++++
 rtl/decoder38_hold.sv | 92 +++++++++
 tb/tb_decoder38_hold.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/decoder38_pkg.sv
// Shared definitions for the registered 3-to-8 decoder with hold timer.
//   state_t             : top-level FSM state (IDLE / HOLD)
//   HOLD_CYCLES_DEFAULT : default length of the hold window in clock cycles
//   dec38()             : 3-bit binary code to 8-bit one-hot
package decoder38_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int unsigned HOLD_CYCLES_DEFAULT = 16;

    function automatic logic [7:0] dec38(input logic [2:0] code);
        return 8'b1 << code;
    endfunction

endpackage

// File: rtl/decoder38_hold_timer.sv
// Hold-window countdown timer.
//   clk        : system clock
//   rst        : synchronous reset, active-high
//   clear      : synchronous abort of a running window
//   load       : start a window; counter takes load_value
//   load_value : cycles-minus-one of the window
//   expired    : final cycle of the running window (counter at zero)
//   busy       : a window is running
module hold_timer #(
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    output logic             expired,
    output logic             busy
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
            busy  <= 1'b0;
        end else if (load) begin
            count <= load_value;
            busy  <= 1'b1;
        end else if (busy) begin
            if (count == '0) begin
                busy <= 1'b0;
            end else begin
                count <= count - 1'b1;
            end
        end
    end

    assign expired = busy && (count == '0);

endmodule

// File: rtl/decoder38_hold.sv
// Registered 3-to-8 decoder with hold timer; receive end of the priority
// encoder's code + indicator pair. Each accepted code drives the LED bank
// for HOLD_CYCLES cycles, optionally OR-ing into a sticky mask.
//   clk, rst      : clock, synchronous active-high reset
//   code_in       : 3-bit binary code
//   indicator_in  : 1 = code_in meaningful, 0 = upstream saw all-zero input
//   code_valid    : upstream offers a transfer
//   code_ready    : block can accept this cycle (combinational)
//   enable_in     : 0 = refuse new codes (a running hold still completes)
//   accum         : sampled at acceptance; 1 = accumulate into sticky mask
//   clear         : synchronous clear of mask/state/counter (count kept)
//   onehot_out    : decoded LED pattern
//   code_latched  : last accepted code that had indicator_in=1
//   busy          : high while a hold window runs
//   accept_cnt    : accepted transfers, wraps 255->0
module decoder38_hold
    import decoder38_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEFAULT,
    parameter int unsigned CNT_W       = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] code_in,
    input  logic       indicator_in,
    input  logic       code_valid,
    output logic       code_ready,
    input  logic       enable_in,
    input  logic       accum,
    input  logic       clear,
    output logic [7:0] onehot_out,
    output logic [2:0] code_latched,
    output logic       busy,
    output logic [7:0] accept_cnt
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(HOLD_CYCLES - 1);

    state_t state;
    logic   accum_flag;
    logic   accept;
    logic   expired;
    logic   timer_busy;

    assign code_ready = (state == IDLE) && enable_in && !clear && !rst;
    assign accept     = code_valid && code_ready;
    assign busy       = timer_busy;

    // Only a meaningful code opens a hold window; timer and FSM move together.
    hold_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .load      (accept && indicator_in),
        .load_value(LOAD_VAL),
        .expired   (expired),
        .busy      (timer_busy)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            onehot_out   <= '0;
            code_latched <= '0;
            accum_flag   <= 1'b0;
            accept_cnt   <= '0;
        end else if (clear) begin
            state        <= IDLE;
            onehot_out   <= '0;
            code_latched <= '0;
            accum_flag   <= 1'b0;
        end else if (accept) begin
            accept_cnt <= accept_cnt + 8'd1;
            if (indicator_in) begin
                onehot_out   <= accum ? (onehot_out | dec38(code_in)) : dec38(code_in);
                code_latched <= code_in;
                accum_flag   <= accum;
                state        <= HOLD;
            end else if (!accum) begin
                onehot_out <= '0;
            end
        end else if (state == HOLD && expired) begin
            state <= IDLE;
            if (!accum_flag) begin
                onehot_out <= '0;
            end
        end
    end

endmodule

// File: tb/tb_decoder38_hold.sv
// Self-checking bench for decoder38_hold. Two instances share stimulus:
// u_dut0 with a 4-cycle hold and u_dut1 with the 1-cycle minimum hold.
module tb_decoder38_hold;

    logic       clk = 1'b0;
    logic       rst, indicator_in, code_valid, enable_in, accum, clear;
    logic [2:0] code_in;

    logic       ready0, busy0, ready1, busy1;
    logic [7:0] onehot0, cnt0, onehot1, cnt1;
    logic [2:0] lat0, lat1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    decoder38_hold #(.HOLD_CYCLES(4), .CNT_W(3)) u_dut0 (
        .clk(clk), .rst(rst), .code_in(code_in), .indicator_in(indicator_in),
        .code_valid(code_valid), .code_ready(ready0), .enable_in(enable_in),
        .accum(accum), .clear(clear), .onehot_out(onehot0),
        .code_latched(lat0), .busy(busy0), .accept_cnt(cnt0)
    );

    decoder38_hold #(.HOLD_CYCLES(1), .CNT_W(1)) u_dut1 (
        .clk(clk), .rst(rst), .code_in(code_in), .indicator_in(indicator_in),
        .code_valid(code_valid), .code_ready(ready1), .enable_in(enable_in),
        .accum(accum), .clear(clear), .onehot_out(onehot1),
        .code_latched(lat1), .busy(busy1), .accept_cnt(cnt1)
    );

    // Behavioural model: per instance, busy cycles remaining plus the
    // visible registers, stepped once per rising edge.
    int         hold_len [2] = '{4, 1};
    int         m_rem    [2];
    logic [7:0] m_mask   [2];
    logic [2:0] m_lat    [2];
    int         m_cnt    [2];
    bit         m_sticky [2];
    bit         mon_on = 1'b0;

    function automatic bit m_ready(input int i);
        return (m_rem[i] == 0) && enable_in && !clear && !rst;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_rem[i] = 0; m_mask[i] = 0; m_lat[i] = 0; m_cnt[i] = 0; m_sticky[i] = 0;
            end else if (clear) begin
                m_rem[i] = 0; m_mask[i] = 0; m_lat[i] = 0; m_sticky[i] = 0;
            end else if (code_valid && m_ready(i)) begin
                m_cnt[i] = (m_cnt[i] + 1) % 256;
                if (indicator_in) begin
                    m_mask[i]   = (accum ? m_mask[i] : 8'h00) | 8'(1 << code_in);
                    m_lat[i]    = code_in;
                    m_sticky[i] = accum;
                    m_rem[i]    = hold_len[i];
                end else if (!accum) begin
                    m_mask[i] = 8'h00;
                end
            end else if (m_rem[i] > 0) begin
                m_rem[i] = m_rem[i] - 1;
                if (m_rem[i] == 0 && !m_sticky[i]) m_mask[i] = 8'h00;
            end
        end
        if (rst) mon_on = 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (mon_on) begin
            chk("m0_onehot", 32'(onehot0), 32'(m_mask[0]));
            chk("m0_latched", 32'(lat0), 32'(m_lat[0]));
            chk("m0_busy", 32'(busy0), 32'(m_rem[0] > 0));
            chk("m0_cnt", 32'(cnt0), 32'(m_cnt[0]));
            chk("m0_ready", 32'(ready0), 32'(m_ready(0)));
            chk("m1_onehot", 32'(onehot1), 32'(m_mask[1]));
            chk("m1_latched", 32'(lat1), 32'(m_lat[1]));
            chk("m1_busy", 32'(busy1), 32'(m_rem[1] > 0));
            chk("m1_cnt", 32'(cnt1), 32'(m_cnt[1]));
            chk("m1_ready", 32'(ready1), 32'(m_ready(1)));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1; clear = 0; code_valid = 0; indicator_in = 0; code_in = 0;
        enable_in = 1; accum = 0;
        step(); step();
        rst = 0;
        #1;
        chk("rst_onehot", 32'(onehot0), 32'h00);
        chk("rst_busy", 32'(busy0), 32'h0);
        chk("rst_cnt", 32'(cnt0), 32'h0);
        chk("rst_ready", 32'(ready0), 32'h1);

        // Single decode of code 5, 4-cycle hold.
        code_in = 3'd5; indicator_in = 1; code_valid = 1; accum = 0;
        step();
        code_valid = 0;
        chk("single_onehot", 32'(onehot0), 32'h20);
        chk("single_ready", 32'(ready0), 32'h0);
        chk("single_latched", 32'(lat0), 32'd5);
        chk("single_cnt", 32'(cnt0), 32'd1);
        chk("h1_busy_first", 32'(busy1), 32'h1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("single_hold", 32'(onehot0), 32'h20);
            chk("single_busy", 32'(busy0), 32'h1);
        end
        chk("h1_busy_done", 32'(busy1), 32'h0);
        step();
        chk("single_end", 32'(onehot0), 32'h00);
        chk("single_end_busy", 32'(busy0), 32'h0);

        // Back-to-back under backpressure: code 2 then code 7.
        code_in = 3'd2; code_valid = 1;
        step();
        chk("b2b_first", 32'(onehot0), 32'h04);
        code_in = 3'd7;
        repeat (4) step();
        chk("b2b_gap", 32'(onehot0), 32'h00);
        chk("b2b_gap_cnt", 32'(cnt0), 32'd2);
        n = 0;
        while (cnt0 == 8'd2 && n < 20) begin
            step();
            n++;
        end
        chk("b2b_spacing", 32'(4 + n), 32'd5);
        chk("b2b_second", 32'(onehot0), 32'h80);
        code_valid = 0;
        repeat (4) step();

        // Accumulate codes 0, 3, 6 from a fresh reset.
        rst = 1; step(); rst = 0;
        code_in = 3'd0; accum = 1; code_valid = 1;
        step();
        code_valid = 0; accum = 0;
        chk("acc_0", 32'(onehot0), 32'h01);
        repeat (4) step();
        code_in = 3'd3; accum = 1; code_valid = 1;
        step();
        code_valid = 0; accum = 0;
        chk("acc_3", 32'(onehot0), 32'h09);
        repeat (4) step();
        code_in = 3'd6; accum = 1; code_valid = 1;
        step();
        code_valid = 0; accum = 0;
        chk("acc_6", 32'(onehot0), 32'h49);
        repeat (4) step();
        chk("acc_kept", 32'(onehot0), 32'h49);
        chk("acc_idle", 32'(busy0), 32'h0);
        clear = 1;
        step();
        clear = 0;
        chk("clr_onehot", 32'(onehot0), 32'h00);
        chk("clr_cnt", 32'(cnt0), 32'd3);

        // No-input code over a prior sticky mask of 0x10.
        code_in = 3'd4; accum = 1; code_valid = 1;
        step();
        code_valid = 0; accum = 0;
        repeat (4) step();
        chk("noin_prior", 32'(onehot0), 32'h10);
        code_in = 3'd0; indicator_in = 0; code_valid = 1;
        step();
        code_valid = 0; indicator_in = 1;
        chk("noin_onehot", 32'(onehot0), 32'h00);
        chk("noin_busy", 32'(busy0), 32'h0);
        chk("noin_cnt", 32'(cnt0), 32'd5);
        chk("noin_latched", 32'(lat0), 32'd4);

        // Clear mid-hold with a same-cycle valid.
        code_in = 3'd1; code_valid = 1;
        step();
        code_valid = 0;
        step();
        clear = 1; code_valid = 1; code_in = 3'd6;
        step();
        clear = 0; code_valid = 0;
        chk("clrh_onehot", 32'(onehot0), 32'h00);
        chk("clrh_busy", 32'(busy0), 32'h0);
        chk("clrh_cnt", 32'(cnt0), 32'd6);

        // enable_in dropped mid-hold.
        code_in = 3'd2; code_valid = 1;
        step();
        code_valid = 0; enable_in = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("en_hold_busy", 32'(busy0), 32'h1);
        end
        step();
        chk("en_done_busy", 32'(busy0), 32'h0);
        chk("en_done_ready", 32'(ready0), 32'h0);
        code_in = 3'd3; code_valid = 1;
        step();
        chk("en_refused", 32'(cnt0), 32'd7);
        enable_in = 1;
        #1;
        chk("en_ready", 32'(ready0), 32'h1);
        step();
        code_valid = 0;
        chk("en_accept_cnt", 32'(cnt0), 32'd8);
        chk("en_accept_onehot", 32'(onehot0), 32'h08);
        repeat (6) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
